// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for the counter sequence checker.
//   - FSM state encoding (SEEK / LOCKED)
//   - default parameter values for WIDTH, LOCK_CNT and ERR_W
package count_seq_checker_pkg;

  // Default counter width: cnt_in = {A2,A1,A0}
  localparam int unsigned DEF_WIDTH    = 3;
  // Consecutive correct transitions required before declaring lock
  localparam int unsigned DEF_LOCK_CNT = 4;
  // Width of the saturating error counter
  localparam int unsigned DEF_ERR_W    = 8;

  typedef enum logic {
    ST_SEEK   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage : count_seq_checker_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and increment.
// A clear and an increment in the same cycle clear first, then count,
// so the result is 1. At all-ones the count holds.
// Ports:
//   clk      in  1  rising-edge clock
//   rst_n    in  1  asynchronous active-low reset
//   clr_i    in  1  synchronous clear
//   inc_i    in  1  increment request
//   count_o  out W  current count (registered)
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] base_c;

  // Clear takes effect before the increment is applied
  always_comb begin
    base_c  = clr_i ? '0 : count_q;
    count_d = base_c;
    if (inc_i && (base_c != '1)) begin
      count_d = base_c + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/count_seq_checker.sv
// Receive-side monitor for a T-enabled binary counter. Every clock edge it
// compares the sampled count with the value predicted from the previous
// sample (prev + prev_T, mod 2^WIDTH). After LOCK_CNT consecutive correct
// transitions it enters LOCKED; any mismatch while LOCKED raises a one-cycle
// err_pulse, bumps the saturating err_count and drops back to SEEK.
// Ports:
//   clk        in  1      rising-edge clock shared with the counter
//   rst_n      in  1      asynchronous active-low reset
//   cnt_in     in  WIDTH  counter value, bit0 = A0
//   T          in  1      counter toggle enable
//   clr        in  1      synchronous clear of err_count
//   locked     out 1      high while in LOCKED
//   err_pulse  out 1      one-cycle pulse per LOCKED mismatch
//   err_count  out ERR_W  saturating count of LOCKED mismatches
//   expected   out WIDTH  prediction for the current cycle's cnt_in
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             T,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);

  state_e             state_q;
  state_e             state_d;
  logic [RUN_W-1:0]   run_q;
  logic [RUN_W-1:0]   run_d;
  logic               err_pulse_q;
  logic               err_pulse_d;
  logic               prev_valid_q;
  logic [WIDTH-1:0]   expected_q;
  logic               match_c;
  logic               err_inc_c;

  // Prediction pipeline: holding prev_cnt + prev_T directly is equivalent
  // to storing prev_cnt and prev_T and adding them afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_q   <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      expected_q   <= cnt_in + WIDTH'(T);
      prev_valid_q <= 1'b1;
    end
  end

  assign match_c = (cnt_in == expected_q);

  // FSM state, lock-run counter and error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEEK;
      run_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Next-state logic; comparisons are suppressed until a prior sample exists
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    err_pulse_d = 1'b0;
    err_inc_c   = 1'b0;

    if (prev_valid_q) begin
      case (state_q)
        ST_SEEK: begin
          if (match_c) begin
            if (run_q == RUN_W'(LOCK_CNT - 1)) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!match_c) begin
            err_pulse_d = 1'b1;
            err_inc_c   = 1'b1;
            state_d     = ST_SEEK;
            run_d       = '0;
          end
        end
        default: begin
          state_d = ST_SEEK;
          run_d   = '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .inc_i   (err_inc_c),
    .count_o (err_count)
  );

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

endmodule : count_seq_checker

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: a default instance (ERR_W=8) and a narrow
// instance (ERR_W=2) see identical stimulus. Directed vectors check against
// hand-computed constants; every step is also compared with a streak-based
// reference model.
module tb_count_seq_checker;

  localparam int unsigned W  = 3;
  localparam int unsigned LC = 4;
  localparam int          MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] cnt_in = '0;
  logic         t = 1'b0;
  logic         clr = 1'b0;

  logic         locked8, pulse8;
  logic [7:0]   errc8;
  logic [W-1:0] exp8;
  logic         locked2, pulse2;
  logic [1:0]   errc2;
  logic [W-1:0] exp2;

  count_seq_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .T(t), .clr(clr),
    .locked(locked8), .err_pulse(pulse8), .err_count(errc8), .expected(exp8)
  );

  count_seq_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .T(t), .clr(clr),
    .locked(locked2), .err_pulse(pulse2), .err_count(errc2), .expected(exp2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int pulse_seen = 0;

  // Reference model: lock means the streak of consecutive correct
  // transitions has reached LC; an error is a break of such a streak.
  int m_has_prev, m_prev_cnt, m_prev_t, m_streak, m_errs, m_pulse, m_exp;

  function automatic void model_reset();
    m_has_prev = 0; m_prev_cnt = 0; m_prev_t = 0;
    m_streak = 0; m_errs = 0; m_pulse = 0; m_exp = 0;
  endfunction

  function automatic void model_edge(input int c, input int tt, input int cl);
    m_pulse = 0;
    if (m_has_prev != 0) begin
      if (c == (m_prev_cnt + m_prev_t) % MOD) begin
        if (m_streak < 1000) m_streak++;
      end else begin
        m_pulse  = (m_streak >= LC) ? 1 : 0;
        m_streak = 0;
      end
    end
    if (cl != 0) m_errs = 0;
    if (m_pulse != 0) m_errs++;
    m_exp      = (c + tt) % MOD;
    m_prev_cnt = c;
    m_prev_t   = tt;
    m_has_prev = 1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model();
    chk("m8_locked", int'(locked8), (m_streak >= LC) ? 1 : 0);
    chk("m8_pulse",  int'(pulse8),  m_pulse);
    chk("m8_errc",   int'(errc8),   sat(m_errs, 255));
    chk("m8_exp",    int'(exp8),    m_exp);
    chk("m2_locked", int'(locked2), (m_streak >= LC) ? 1 : 0);
    chk("m2_pulse",  int'(pulse2),  m_pulse);
    chk("m2_errc",   int'(errc2),   sat(m_errs, 3));
    chk("m2_exp",    int'(exp2),    m_exp);
  endtask

  // Drive one sample, clock it in, then compare just after the edge
  task automatic step(input int c, input int tt, input int cl);
    cnt_in = W'(c);
    t      = tt[0];
    clr    = cl[0];
    @(posedge clk);
    model_edge(c, tt, cl);
    #1;
    if (pulse2) pulse_seen++;
    check_model();
  endtask

  // Called at posedge+1; pulses reset between edges
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int c; int t; int clr;
    int locked; int pulse; int errc; int expv;
  } vec_t;

  vec_t vecs[21];
  int   cur;

  initial begin
    // Lock-in, wrap, single bad sample, T=0 hold and T=0 change
    vecs[0]  = '{0, 1, 0, 0, 0, 0, 1};
    vecs[1]  = '{1, 1, 0, 0, 0, 0, 2};
    vecs[2]  = '{2, 1, 0, 0, 0, 0, 3};
    vecs[3]  = '{3, 1, 0, 0, 0, 0, 4};
    vecs[4]  = '{4, 1, 0, 1, 0, 0, 5};
    vecs[5]  = '{5, 1, 0, 1, 0, 0, 6};
    vecs[6]  = '{6, 1, 0, 1, 0, 0, 7};
    vecs[7]  = '{7, 1, 0, 1, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 1, 0, 0, 1};
    vecs[9]  = '{1, 1, 0, 1, 0, 0, 2};
    vecs[10] = '{2, 1, 0, 1, 0, 0, 3};
    vecs[11] = '{3, 1, 0, 1, 0, 0, 4};
    vecs[12] = '{5, 1, 0, 0, 1, 1, 6};
    vecs[13] = '{6, 1, 0, 0, 0, 1, 7};
    vecs[14] = '{7, 1, 0, 0, 0, 1, 0};
    vecs[15] = '{0, 1, 0, 0, 0, 1, 1};
    vecs[16] = '{1, 1, 0, 1, 0, 1, 2};
    vecs[17] = '{2, 0, 0, 1, 0, 1, 2};
    vecs[18] = '{2, 0, 0, 1, 0, 1, 2};
    vecs[19] = '{3, 0, 0, 0, 1, 2, 3};
    vecs[20] = '{3, 1, 0, 0, 0, 2, 4};

    model_reset();
    #1;
    chk("rst_locked", int'(locked8), 0);
    chk("rst_pulse",  int'(pulse8),  0);
    chk("rst_errc",   int'(errc8),   0);
    chk("rst_exp",    int'(exp8),    0);
    #11;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].c, vecs[i].t, vecs[i].clr);
      chk($sformatf("vec%0d_locked", i), int'(locked8), vecs[i].locked);
      chk($sformatf("vec%0d_pulse", i),  int'(pulse8),  vecs[i].pulse);
      chk($sformatf("vec%0d_errc", i),   int'(errc8),   vecs[i].errc);
      chk($sformatf("vec%0d_exp", i),    int'(exp8),    vecs[i].expv);
    end

    // Async reset mid-stream from a locked state with errors recorded
    step(4, 1, 0);
    step(5, 1, 0);
    step(6, 1, 0);
    chk("pre_rst_locked", int'(locked8), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", int'(locked8), 0);
    chk("arst_pulse",  int'(pulse8),  0);
    chk("arst_errc",   int'(errc8),   0);
    chk("arst_exp",    int'(exp8),    0);
    model_reset();
    #2;
    rst_n = 1'b1;
    step(5, 1, 0);
    chk("prime_no_err", int'(pulse8), 0);
    step(6, 1, 0);
    step(7, 1, 0);
    step(0, 1, 0);
    chk("relock_early", int'(locked8), 0);
    step(1, 1, 0);
    chk("relock_done", int'(locked8), 1);

    // Saturation on the narrow instance, then clear coinciding with an error
    do_reset();
    cur = 0;
    step(cur, 1, 0);
    pulse_seen = 0;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < int'(LC); j++) begin
        cur = (cur + 1) % MOD;
        step(cur, 1, 0);
      end
      cur = (cur + 2) % MOD;
      step(cur, 1, 0);
    end
    chk("sat_errc2", int'(errc2), 3);
    chk("sat_errc8", int'(errc8), 5);
    chk("sat_pulses", pulse_seen, 5);
    for (int j = 0; j < int'(LC); j++) begin
      cur = (cur + 1) % MOD;
      step(cur, 1, 0);
    end
    cur = (cur + 2) % MOD;
    step(cur, 1, 1);
    chk("clr_err_errc2", int'(errc2), 1);
    chk("clr_err_errc8", int'(errc8), 1);
    chk("clr_err_pulse", int'(pulse2), 1);
    step((cur + 1) % MOD, 1, 1);
    chk("clr_alone_errc8", int'(errc8), 0);

    // Randomized stream: mostly correct samples, occasional breaks, clears, resets
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int c, tt, cl;
      tt = int'($urandom_range(0, 1));
      if ((m_has_prev != 0) && ($urandom_range(0, 9) != 0))
        c = (m_prev_cnt + m_prev_t) % MOD;
      else
        c = int'($urandom_range(0, MOD - 1));
      cl = ($urandom_range(0, 29) == 0) ? 1 : 0;
      if ($urandom_range(0, 249) == 0) do_reset();
      step(c, tt, cl);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_count_seq_checker
